// File: rtl/cache_dm_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM state
// encoding, default NOP word and a constant-evaluable ceiling log2.
package cache_dm_ctrl_pkg;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_FILL  = 2'd1,
    CS_WRITE = 2'd2
  } cache_state_e;

  // Fed to the I-side pipeline as a NOP while an instruction fetch is stalled.
  localparam logic [15:0] NOP_WORD = 16'hB000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Data, tag and valid arrays of the direct-mapped cache: combinational read by
// index, whole-block fill, single-word write and flush-all.
module cache_line_store
  import cache_dm_ctrl_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int LINES       = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int IDX_W       = 2,
  parameter int OFF_W       = 2,
  parameter int TAG_W       = 12
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [OFF_W-1:0]              off_i,
  input  logic                          flush_i,
  input  logic                          fill_en_i,
  input  logic [TAG_W-1:0]              fill_tag_i,
  input  logic [BLOCK_WORDS*WORD_W-1:0] fill_block_i,
  input  logic                          wr_en_i,
  input  logic [WORD_W-1:0]             wr_data_i,
  output logic                          valid_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic [WORD_W-1:0]             words_o [BLOCK_WORDS]
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES][BLOCK_WORDS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // NOTE: the data and tag arrays are deliberately not reset; only the valid
  // bits carry meaning after reset, which keeps the arrays RAM-mappable.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (fill_en_i) begin
        tag_q[idx_i] <= fill_tag_i;
        for (int w = 0; w < BLOCK_WORDS; w++) begin
          data_q[idx_i][w] <= fill_block_i[(BLOCK_WORDS-1-w)*WORD_W +: WORD_W];
        end
      end
      if (wr_en_i) begin
        data_q[idx_i][off_i] <= wr_data_i;
      end
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign words_o = data_q[idx_i];

endmodule

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between a
// CPU port and a block-wide memory with a ready handshake.
module cache_dm_ctrl
  import cache_dm_ctrl_pkg::*;
#(
  parameter int               WORD_W      = 16,
  parameter int               ADDR_W      = 16,
  parameter int               LINES       = 4,
  parameter int               BLOCK_WORDS = 4,
  parameter int               CNT_W       = 16,
  parameter logic [WORD_W-1:0] MISS_WORD  = WORD_W'(NOP_WORD)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [WORD_W-1:0]             cpu_wdata,
  output logic [WORD_W-1:0]             cpu_rdata,
  output logic                          cpu_ready,
  input  logic                          flush,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WORD_W-1:0]             mem_wdata,
  input  logic [BLOCK_WORDS*WORD_W-1:0] mem_rdata,
  input  logic                          mem_ready,
  output logic [CNT_W-1:0]              num_access,
  output logic [CNT_W-1:0]              num_miss
);

  localparam int OFF_W = clog2(BLOCK_WORDS);
  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  assign offset = cpu_addr[OFF_W-1:0];
  assign index  = cpu_addr[OFF_W +: IDX_W];
  assign tag    = cpu_addr[ADDR_W-1 -: TAG_W];

  cache_state_e     state_q, state_d;
  logic             whit_q, whit_d;
  logic [CNT_W-1:0] access_q, access_d, miss_q, miss_d;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [WORD_W-1:0] line_words [BLOCK_WORDS];
  logic              hit, rd_miss, fill_en, wr_en;

  cache_line_store #(
    .WORD_W      (WORD_W),
    .LINES       (LINES),
    .BLOCK_WORDS (BLOCK_WORDS),
    .IDX_W       (IDX_W),
    .OFF_W       (OFF_W),
    .TAG_W       (TAG_W)
  ) u_store (
    .clk          (clk),
    .reset_n      (reset_n),
    .idx_i        (index),
    .off_i        (offset),
    .flush_i      (flush),
    .fill_en_i    (fill_en),
    .fill_tag_i   (tag),
    .fill_block_i (mem_rdata),
    .wr_en_i      (wr_en),
    .wr_data_i    (cpu_wdata),
    .valid_o      (line_valid),
    .tag_o        (line_tag),
    .words_o      (line_words)
  );

  assign hit     = line_valid && (line_tag == tag);
  assign rd_miss = (state_q == CS_IDLE) && cpu_req && !cpu_we && !hit;
  assign fill_en = (state_q == CS_FILL) && mem_ready;
  // A write miss only goes to memory; the line is touched only if it hit at issue.
  assign wr_en   = (state_q == CS_WRITE) && mem_ready && whit_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= CS_IDLE;
      whit_q   <= 1'b0;
      access_q <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      whit_q   <= whit_d;
      access_q <= access_d;
      miss_q   <= miss_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    whit_d  = whit_q;
    case (state_q)
      CS_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = CS_WRITE;
            whit_d  = hit;
          end else if (!hit) begin
            state_d = CS_FILL;
          end
        end
      end
      CS_FILL, CS_WRITE: if (mem_ready) state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      CS_IDLE: cpu_ready = cpu_req && !cpu_we && hit;
      CS_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, index, {OFF_W{1'b0}}};
      end
      CS_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = (cpu_ready && !cpu_we) ? line_words[offset] : MISS_WORD;

  // Counters wrap naturally at 2^CNT_W.
  assign access_d   = access_q + CNT_W'(cpu_req && cpu_ready);
  assign miss_d     = miss_q + CNT_W'(rd_miss);
  assign num_access = access_q;
  assign num_miss   = miss_q;

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// Self-checking bench: transaction-level cache model plus a per-cycle compare
// process, directed scenarios pinned with literals, then randomized traffic.
module tb_cache_dm_ctrl;

  localparam logic [15:0] MISS = 16'hB000;

  logic        clk;
  logic        reset_n, cpu_req, cpu_we, flush, mem_ready;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata;
  logic [15:0] num_access, num_miss;
  logic        cpu_ready, mem_req, mem_we;
  logic [63:0] mem_rdata;

  cache_dm_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .num_access (num_access),
    .num_miss   (num_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cache model: 4 lines x 4 words, address = tag*16 + index*4 + offset.
  bit          m_valid [4];
  int          m_tag   [4];
  logic [15:0] m_data  [4][4];
  int unsigned m_acc, m_miss;

  function automatic int f_idx(input logic [15:0] a); return (int'(a) / 4) % 4; endfunction
  function automatic int f_off(input logic [15:0] a); return int'(a) % 4; endfunction
  function automatic int f_tag(input logic [15:0] a); return int'(a) / 16; endfunction
  function automatic bit m_hit(input logic [15:0] a);
    return m_valid[f_idx(a)] && (m_tag[f_idx(a)] == f_tag(a));
  endfunction

  task automatic m_flush();
    for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
  endtask

  // Expected outputs for the current cycle.
  bit          e_chk = 1'b0;
  bit          e_ready, e_mreq, e_mwe;
  logic [15:0] e_rdata, e_maddr, e_mwdata, e_acc, e_miss;

  task automatic set_exp(input bit rdy, input logic [15:0] rd, input bit mreq,
                         input bit mwe, input logic [15:0] maddr, input logic [15:0] mwd);
    e_chk = 1'b1; e_ready = rdy; e_rdata = rd; e_mreq = mreq; e_mwe = mwe;
    e_maddr = maddr; e_mwdata = mwd; e_acc = 16'(m_acc); e_miss = 16'(m_miss);
  endtask

  int          last_rdy_cyc = 0;
  int          mreq_cnt     = 0;
  logic [15:0] last_rdata   = '0;
  logic [15:0] last_maddr   = '0;
  logic        last_mwe     = 1'b0;

  always @(negedge clk) begin
    if (e_chk) begin
      check("cpu_ready", cpu_ready, e_ready);
      check("cpu_rdata", cpu_rdata, e_rdata);
      check("mem_req", mem_req, e_mreq);
      check("num_access", num_access, e_acc);
      check("num_miss", num_miss, e_miss);
      if (e_mreq) begin
        check("mem_we", mem_we, e_mwe);
        check("mem_addr", mem_addr, e_maddr);
        if (e_mwe) check("mem_wdata", mem_wdata, e_mwdata);
      end
      if (cpu_ready) begin
        last_rdy_cyc <= cyc;
        last_rdata   <= cpu_rdata;
      end
      if (mem_req) begin
        last_maddr <= mem_addr;
        last_mwe   <= mem_we;
        mreq_cnt   <= mreq_cnt + 1;
      end
    end
  end

  task automatic begin_cycle(); @(posedge clk); #1; endtask
  task automatic end_cycle();   @(negedge clk); #1; endtask

  int op_start_cyc, op_start_mreq;

  task automatic do_reset(input int n);
    repeat (n) begin
      begin_cycle();
      reset_n = 1'b0; cpu_req = 1'b0; flush = 1'b0; mem_ready = 1'b0; e_chk = 1'b0;
      end_cycle();
    end
    m_flush();
    m_acc = 0;
    m_miss = 0;
  endtask

  task automatic idle_cycle(input bit fl);
    begin_cycle();
    reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
    flush = fl; mem_ready = 1'b0; mem_rdata = {$urandom, $urandom};
    set_exp(1'b0, MISS, 1'b0, 1'b0, '0, '0);
    end_cycle();
    if (fl) m_flush();
  endtask

  // One CPU request held until completion; memory answers each transaction
  // after lat cycles, and flush is pulsed once at op cycle flush_at.
  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [15:0] wd,
                        input int lat, input int flush_at, input logic [63:0] blk);
    bit in_mem, whit, done, last, fl;
    int waitc, c;
    logic [15:0] al;
    in_mem = 0; whit = 0; done = 0; waitc = 0; c = 0;
    al = 16'(int'(a) / 4 * 4);
    while (!done) begin
      begin_cycle();
      if (c == 0) begin
        op_start_cyc  = cyc;
        op_start_mreq = mreq_cnt;
      end
      reset_n = 1'b1; cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      fl = (c == flush_at); flush = fl;
      mem_ready = 1'b0; mem_rdata = {$urandom, $urandom};
      last = 1'b0;
      if (!in_mem) begin
        if (!we && m_hit(a)) set_exp(1'b1, m_data[f_idx(a)][f_off(a)], 1'b0, 1'b0, '0, '0);
        else                 set_exp(1'b0, MISS, 1'b0, 1'b0, '0, '0);
      end else begin
        waitc++;
        last = (waitc >= lat);
        mem_ready = last;
        if (last) mem_rdata = blk;
        set_exp(we && last, MISS, 1'b1, we, we ? a : al, wd);
      end
      end_cycle();
      if (!in_mem) begin
        if (we) begin
          in_mem = 1; whit = m_hit(a); waitc = 0;
        end else if (m_hit(a)) begin
          m_acc++; done = 1;
        end else begin
          m_miss++; in_mem = 1; waitc = 0;
        end
      end else if (last) begin
        in_mem = 0;
        if (we) begin
          m_acc++; done = 1;
          if (whit) m_data[f_idx(a)][f_off(a)] = wd;
        end else begin
          for (int k = 0; k < 4; k++) m_data[f_idx(a)][k] = blk[(3-k)*16 +: 16];
          m_tag[f_idx(a)]   = f_tag(a);
          m_valid[f_idx(a)] = 1'b1;
        end
      end
      if (fl) m_flush();
      c++;
      if (!done && c > 60) begin
        total++; bad++;
        $display("FAIL op_bound: request at %0h not completed after %0d cycles", a, c);
        done = 1;
      end
    end
  endtask

  bit          r_we;
  logic [15:0] r_a;
  int          r_lat, r_fl;

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    do_reset(2);

    idle_cycle(1'b0);
    check("rst_access", num_access, 16'd0);
    check("rst_miss", num_miss, 16'd0);
    check("rst_mem_req", mem_req, 1'b0);

    // Cold read miss, memory answers on the 3rd FILL cycle.
    cpu_op(1'b0, 16'h0010, 16'h0, 3, -1, 64'h1111_2222_3333_4444);
    check("tp1_latency", last_rdy_cyc - op_start_cyc, 4);
    check("tp1_rdata", last_rdata, 16'h1111);
    check("tp1_mem_addr", last_maddr, 16'h0010);
    idle_cycle(1'b0);
    check("tp1_miss", num_miss, 16'd1);
    check("tp1_access", num_access, 16'd1);

    cpu_op(1'b0, 16'h0013, 16'h0, 1, -1, 64'h0);
    check("tp2_latency", last_rdy_cyc - op_start_cyc, 0);
    check("tp2_rdata", last_rdata, 16'h4444);
    check("tp2_no_mem_req", mreq_cnt - op_start_mreq, 0);

    cpu_op(1'b1, 16'h0011, 16'hABCD, 2, -1, 64'h0);
    check("tp3_mem_we", last_mwe, 1'b1);
    check("tp3_mem_addr", last_maddr, 16'h0011);
    cpu_op(1'b0, 16'h0011, 16'h0, 1, -1, 64'h0);
    check("tp3_rdata", last_rdata, 16'hABCD);
    check("tp3_latency", last_rdy_cyc - op_start_cyc, 0);

    // Write miss on index 0 must not evict the resident line.
    cpu_op(1'b1, 16'h0050, 16'h5555, 1, -1, 64'h0);
    check("tp4_mem_addr", last_maddr, 16'h0050);
    cpu_op(1'b0, 16'h0010, 16'h0, 1, -1, 64'h0);
    check("tp4_rdata", last_rdata, 16'h1111);
    check("tp4_latency", last_rdy_cyc - op_start_cyc, 0);
    idle_cycle(1'b0);
    check("tp4_miss", num_miss, 16'd1);
    check("tp4_access", num_access, 16'd6);

    // Flush coinciding with FILL completion: the read misses a second time.
    cpu_op(1'b0, 16'h0014, 16'h0, 2, 2, 64'h0A0A_0B0B_0C0C_0D0D);
    check("tp5_latency", last_rdy_cyc - op_start_cyc, 6);
    check("tp5_rdata", last_rdata, 16'h0A0A);
    idle_cycle(1'b0);
    check("tp5_miss", num_miss, 16'd3);

    // Reset in the middle of a FILL, with memory answering in that very cycle.
    begin_cycle();
    reset_n = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0028; flush = 1'b0;
    mem_ready = 1'b0;
    set_exp(1'b0, MISS, 1'b0, 1'b0, '0, '0);
    end_cycle();
    m_miss++;
    begin_cycle();
    set_exp(1'b0, MISS, 1'b1, 1'b0, 16'h0028, '0);
    end_cycle();
    begin_cycle();
    reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = 64'h7777_8888_9999_AAAA; e_chk = 1'b0;
    end_cycle();
    m_flush();
    m_acc = 0;
    m_miss = 0;
    idle_cycle(1'b0);
    check("rst6_mem_req", mem_req, 1'b0);
    check("rst6_miss", num_miss, 16'd0);
    check("rst6_access", num_access, 16'd0);
    cpu_op(1'b0, 16'h0028, 16'h0, 1, -1, 64'h1234_5678_9ABC_DEF0);
    check("rst6_refill_latency", last_rdy_cyc - op_start_cyc, 2);
    check("rst6_rdata", last_rdata, 16'h1234);
    idle_cycle(1'b0);
    check("rst6_miss_after", num_miss, 16'd1);

    // Randomized traffic over a few tags so hits, misses and conflicts all occur.
    for (int n = 0; n < 400; n++) begin
      r_we  = ($urandom_range(0, 9) < 3);
      r_a   = 16'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r_a = r_a ^ 16'h8000;
      r_lat = $urandom_range(1, 4);
      r_fl  = ($urandom_range(0, 99) < 15) ? $urandom_range(0, r_lat) : -1;
      cpu_op(r_we, r_a, 16'($urandom), r_lat, r_fl, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle_cycle($urandom_range(0, 7) == 0);
    end
    idle_cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_dm_ctrl.md
Name: cache_dm_ctrl

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache controller.
- Sits between a CPU port (instruction or data side) and a block-wide memory with a ready handshake.
- Supersedes the fixed 4-line, 4-word, 16-bit cache. Adds configurable geometry, an explicit FSM, true valid bits, a memory handshake instead of a fixed latency, flush, and hit/miss statistics.

Parameters:
- WORD_W, 16, data word width in bits.
- ADDR_W, 16, word-address width.
- LINES, 4, number of cache lines; power of two, at least 2.
- BLOCK_WORDS, 4, words per line; power of two, at least 2.
- CNT_W, 16, statistics counter width.
- MISS_WORD, 16'hB000, value driven on cpu_rdata while a read is not ready (NOP for the I-side).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cpu_req  in  1  request valid; held stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  WORD_W  write data
- cpu_rdata  out  WORD_W  read data; valid when cpu_ready && !cpu_we
- cpu_ready  out  1  request completes this cycle
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request
- mem_we  out  1  memory write (single word)
- mem_addr  out  ADDR_W  block-aligned on reads, word address on writes
- mem_wdata  out  WORD_W  write word
- mem_rdata  in  BLOCK_WORDS*WORD_W  fill block; word 0 in the MSBs
- mem_ready  in  1  memory done; rdata valid in the same cycle
- num_access  out  CNT_W  completed requests
- num_miss  out  CNT_W  read misses

Behaviour:
- Address split:
  - offset = cpu_addr[OFF_W-1:0], OFF_W = clog2(BLOCK_WORDS).
  - index = next IDX_W bits, IDX_W = clog2(LINES).
  - tag = remaining TAG_W = ADDR_W-OFF_W-IDX_W bits.
- hit = valid[index] && tag_bank[index]==tag. Combinational in IDLE.
- Reset:
  - state = IDLE; all valid = 0.
  - mem_req = mem_we = 0; cpu_ready = 0.
  - Counters = 0. Data and tags are don't-care.
  - Reset mid-FILL/WRITE abandons the transaction; the line is not written.
- States: IDLE, FILL, WRITE.
- IDLE:
  - Read hit: cpu_ready = 1 combinationally; cpu_rdata = selected word. Zero-wait hit.
  - Read miss: next state FILL; num_miss++.
  - Write (hit or miss): next state WRITE; latch hit flag as whit.
  - No request: stay.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag,index,OFF_W'b0}.
  - On mem_ready: data_bank[index] <= mem_rdata; tag_bank <= tag; valid <= 1; go to IDLE.
  - The held request then hits next cycle. Miss latency = memory cycles + 1.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
  - On mem_ready: cpu_ready = 1; if whit, update only word[offset] of the line; go to IDLE.
  - A write miss never allocates.
- cpu_rdata = MISS_WORD whenever cpu_ready is 0 or cpu_we is 1.
- num_access increments on every cycle with cpu_req && cpu_ready. Both counters wrap modulo 2^CNT_W.
- flush:
  - Clears all valid bits at the clock edge.
  - If it coincides with a FILL completion, flush wins (the line stays invalid) and the FILL returns to IDLE.
  - During WRITE, the word update still occurs but valid stays cleared.
- cpu_req deasserted mid-FILL/WRITE is illegal. The controller completes the memory transaction anyway.
- Outputs mem_* are registered-state decodes (Moore); cpu_ready is Mealy in IDLE.

Decomposition:
- Shared header cache_defs.vh:
  - State encodings CS_IDLE/CS_FILL/CS_WRITE.
  - clog2 function.
  - Default NOP word (MISS_WORD default).
- One sub-module, cache_line_store: the data/tag/valid arrays.
  - Read by index (combinational).
  - Block fill, single-word write, flush-all.
  - FSM and counters stay in the top.

Test Plan:
- Reset, then read addr 0x0010, memory returns block 0x1111_2222_3333_4444 after 3 cycles -> mem_addr = 0x0010, cpu_ready in cycle 5, rdata = 0x1111, num_miss = 1, num_access = 1.
- Then read 0x0013 -> same-cycle cpu_ready, rdata = 0x4444, no mem_req, num_miss stays 1.
- Write 0x0011 = 0xABCD (hit) with mem_ready after 2 cycles -> mem_we = 1, mem_addr = 0x0011; subsequent read 0x0011 hits, returns 0xABCD.
- Write 0x0050 (miss, index 0 conflict) -> memory write only; read 0x0010 still hits, num_miss unchanged.
- flush asserted in the same cycle as FILL mem_ready -> valid stays 0; the held read misses again, num_miss +1.
- reset_n low during FILL -> next cycle mem_req = 0, state IDLE, counters 0, the following read of the same address misses.
